// File: rtl/median_burst_tx.sv
// median_burst_tx: FIFO-buffered transmitter emitting BURST_LEN-word bursts, each followed by GAP_LEN zeroed idle cycles.
// Define MEDIAN_TX_TIMEOUT_EN to flush a partial burst after IDLE_TIMEOUT idle cycles.
module median_burst_tx #(
  parameter int WORD_LEN     = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int BURST_LEN    = 4,
  parameter int GAP_LEN      = 8,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] in_dat,
  input  logic                in_val,
  output logic                in_rdy,
  output logic [WORD_LEN-1:0] dat_o,
  output logic                val_o,
  output logic                busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = $clog2(GAP_LEN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // An illegal parameter set keeps the input closed instead of corrupting the FIFO.
  localparam bit CFG_OK = (FIFO_DEPTH >= BURST_LEN) && (BURST_LEN >= 1) &&
                          (GAP_LEN >= 1) && (IDLE_TIMEOUT >= 1);

  logic [1:0]          state;
  logic [WORD_LEN-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [BW-1:0]       burst_cnt;
  logic [GW-1:0]       gap_cnt;
  logic [BW-1:0]       load_cnt;
  logic                push;
  logic                pop;
  logic                start;

  // Upstream handshake: a word transfers on a rising edge where in_val && in_rdy;
  // in_val is ignored while in_rdy is low, and in_rdy does not depend on in_val.
  assign in_rdy = CFG_OK && !rst && (count < CW'(FIFO_DEPTH));
  assign push   = in_val && in_rdy;
  assign pop    = start || ((state == SEND) && (burst_cnt != '0));

`ifdef MEDIAN_TX_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          timed_out;

  assign timed_out = (state == IDLE) && (count != '0) && (idle_cnt == TW'(IDLE_TIMEOUT));
  assign start     = (state == IDLE) && ((count >= CW'(BURST_LEN)) || timed_out);
  assign load_cnt  = (count >= CW'(BURST_LEN)) ? BW'(BURST_LEN - 1) : BW'(count - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state == IDLE) && (count != '0) && (count < CW'(BURST_LEN)) &&
                 !push && !timed_out) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign start    = (state == IDLE) && (count >= CW'(BURST_LEN));
  assign load_cnt = BW'(BURST_LEN - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale entries are never read because count gates every pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  // burst_cnt holds the words still to pop after the one currently on dat_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      dat_o     <= '0;
      val_o     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            burst_cnt <= load_cnt;
            dat_o     <= mem[rd_ptr];
            val_o     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (burst_cnt != '0) begin
            burst_cnt <= burst_cnt - 1'b1;
            dat_o     <= mem[rd_ptr];
            val_o     <= 1'b1;
          end else begin
            state   <= GAP;
            gap_cnt <= GW'(GAP_LEN - 1);
            dat_o   <= '0;
            val_o   <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          dat_o <= '0;
          val_o <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_burst_tx.sv
// Bench for median_burst_tx: randomized and directed pushes checked cycle by cycle against a burst-schedule reference model.
module tb_median_burst_tx;
  localparam int W = 8;
  localparam int D = 16;
  localparam int B = 4;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_val = 1'b0;
  logic [W-1:0] in_dat = '0;
  logic         in_rdy;
  logic [W-1:0] dat_o;
  logic         val_o;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // Reference model: burst k starts at the first edge n where the FIFO already
  // holds B*(k+1) total pushes and n >= previous start + B + G + 1.
  logic [W-1:0] exp_q[$];
  int n, pushes, popped, bursts, s, earliest, busy_last;
  bit active;

  median_burst_tx #(
    .WORD_LEN(W), .FIFO_DEPTH(D), .BURST_LEN(B), .GAP_LEN(G), .IDLE_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_val(in_val), .in_rdy(in_rdy),
    .dat_o(dat_o), .val_o(val_o), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    n = 0; pushes = 0; popped = 0; bursts = 0; s = 0; earliest = 0;
    busy_last = -1; active = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drives one cycle from a negedge, advances the model over the edge and returns
  // at the next negedge with the expected {val_o, dat_o, busy, in_rdy}.
  task automatic cycle(input logic v, input logic [W-1:0] d,
                       output logic [W+2:0] exp, output logic taken);
    logic rdy_e, val_e, busy_e;
    logic [W-1:0] dat_e;
    rdy_e = (pushes - popped) < D;
    taken = v && rdy_e;
    in_val = v;
    in_dat = d;
    @(posedge clk);
    n++;
    if (!active && n >= earliest && pushes >= B * (bursts + 1)) begin
      active = 1;
      s = n;
    end
    if (taken) begin
      exp_q.push_back(d);
      pushes++;
    end
    val_e = active;
    dat_e = '0;
    if (active) begin
      dat_e = exp_q.pop_front();
      popped++;
    end
    busy_e = active || (n <= busy_last);
    if (active && n == s + B - 1) begin
      active = 0;
      bursts++;
      earliest = s + B + G + 1;
      busy_last = s + B + G - 1;
    end
    rdy_e = (pushes - popped) < D;
    @(negedge clk);
    exp = {val_e, dat_e, busy_e, rdy_e};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_val = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({val_o, dat_o, busy, in_rdy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_values: got %h want %h", {val_o, dat_o, busy, in_rdy}, 11'd0);
    end
    rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_rdy: got %b want 1", in_rdy);
    end
  endtask

  task automatic test_single_burst();
    logic [W+2:0] exp;
    logic tk;
    logic [W-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (i < 4) cycle(1'b1, words[i], exp, tk);
      else       cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL single_burst n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
  endtask

  task automatic test_continuous();
    logic [W+2:0] exp;
    logic tk;
    int sent = 0;
    bit rdy_low = 0;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      if (sent < 16) cycle(1'b1, W'(sent), exp, tk);
      else           cycle(1'b0, W'($urandom), exp, tk);
      if (tk) sent++;
      if (in_rdy !== 1'b1) rdy_low = 1;
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL continuous n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
    tests++;
    if (rdy_low !== 1'b0) begin
      fails++;
      $display("FAIL continuous_rdy_steady: got in_rdy low=%b want 0", rdy_low);
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] exp;
    logic tk;
    int sent = 0;
    int guard = 0;
    bit saw_full = 0;
    do_reset();
    // Enough words at one per cycle to fill the FIFO between bursts.
    while (sent < 32 && guard < 300) begin
      cycle(1'b1, W'($urandom), exp, tk);
      if (tk) sent++;
      guard++;
      if (in_rdy === 1'b0) saw_full = 1;
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL backpressure n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
    tests++;
    if (sent != 32) begin
      fails++;
      $display("FAIL backpressure_accept: got %0d words accepted want 32", sent);
    end
    tests++;
    if (saw_full !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_full: got in_rdy low seen=%b want 1", saw_full);
    end
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL backpressure_drain n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [W+2:0] exp;
    logic tk;
    bit hit = 0;
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      if (i < 4) cycle(1'b1, W'(8'hA0 + i), exp, tk);
      else       cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL mid_burst_pre n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
      if (active && n == s + 1) hit = 1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_burst_reach: got no second burst word want one within 20 cycles");
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({val_o, dat_o, busy, in_rdy} !== 11'd0) begin
      fails++;
      $display("FAIL mid_burst_async: got %h want %h", {val_o, dat_o, busy, in_rdy}, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 45; i++) begin
      if (i < 3)        cycle(1'b1, W'(8'hB0 + i), exp, tk);
      else if (i == 23) cycle(1'b1, 8'hB3, exp, tk);
      else              cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL mid_burst_post n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
  endtask

  task automatic test_partial();
    logic [W+2:0] exp;
    logic tk;
`ifdef MEDIAN_TX_TIMEOUT_EN
    int got = 0;
    int first_hi = -1;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, W'(8'hC0 + i), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL partial_push n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
`ifdef MEDIAN_TX_TIMEOUT_EN
    for (int i = 0; i < 120; i++) begin
      cycle(1'b0, W'($urandom), exp, tk);
      if (val_o === 1'b1) begin
        tests++;
        if (got >= 3 || dat_o !== W'(8'hC0 + got)) begin
          fails++;
          $display("FAIL partial_timeout_word %0d: got %h want %h", got, dat_o, W'(8'hC0 + got));
        end
        if (first_hi < 0) first_hi = i;
        got++;
      end
    end
    tests++;
    if (got != 3 || first_hi < 60) begin
      fails++;
      $display("FAIL partial_timeout_shape: got %0d words from cycle %0d want 3 words after cycle 60", got, first_hi);
    end
`else
    for (int i = 0; i < 120; i++) begin
      cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL partial_hold n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
`endif
    do_reset();
  endtask

  task automatic test_random();
    logic [W+2:0] exp;
    logic tk;
    int pct;
    int guard = 0;
    int rates [4] = '{30, 100, 60, 90};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pct = rates[i / 100];
      cycle(($urandom_range(0, 99) < pct), W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL random n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
    // Top up to whole bursts so everything drains.
    while ((pushes % B) != 0 && guard < 100) begin
      cycle(1'b1, W'($urandom), exp, tk);
      guard++;
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL random_pad n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, W'($urandom), exp, tk);
      tests++;
      if ({val_o, dat_o, busy, in_rdy} !== exp) begin
        fails++;
        $display("FAIL random_drain n=%0d: got %h want %h", n, {val_o, dat_o, busy, in_rdy}, exp);
      end
    end
    tests++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL random_empty: got %0d words left busy=%b want 0 words busy=0", exp_q.size(), busy);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_burst();
    test_continuous();
    test_backpressure();
    test_reset_mid_burst();
    test_partial();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
